// File: rtl/vid_in_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// vid_in_stream_ctrl_if
//   AXI4-Stream video bus of the video-input bridge, as seen by the
//   run-control sequencer.
//
//   Signals:
//     m_axis_video_tvalid  beat valid (driven by the bridge)
//     m_axis_video_tready  beat ready (driven by the downstream sink)
//     m_axis_video_tuser   start-of-frame marker
//     m_axis_video_tlast   end-of-line marker
//
//   Modports:
//     master   the bridge side of the stream
//     slave    the downstream sink of the stream
//     monitor  passive observer; every signal is an input
// ---------------------------------------------------------------------------
interface vid_in_stream_ctrl_if;
  logic m_axis_video_tvalid;
  logic m_axis_video_tready;
  logic m_axis_video_tuser;
  logic m_axis_video_tlast;

  modport master (
    output m_axis_video_tvalid,
    output m_axis_video_tuser,
    output m_axis_video_tlast,
    input  m_axis_video_tready
  );

  modport slave (
    input  m_axis_video_tvalid,
    input  m_axis_video_tuser,
    input  m_axis_video_tlast,
    output m_axis_video_tready
  );

  modport monitor (
    input m_axis_video_tvalid,
    input m_axis_video_tready,
    input m_axis_video_tuser,
    input m_axis_video_tlast
  );
endinterface

// File: rtl/vid_in_stream_ctrl.sv
// ---------------------------------------------------------------------------
// vid_in_stream_ctrl
//   Run-control and health-monitor sequencer for the video-input to
//   AXI4-Stream bridge. Enables the bridge only on a vertical-blank rising
//   edge so streaming starts on a frame boundary, stops at the next frame
//   boundary after run drops, counts frames, and recovers from FIFO write
//   errors and lost input (no start-of-frame while armed) by pulsing the
//   bridge reset.
//
//   Ports:
//     aclk, rst         clock, synchronous active-high reset
//     run               stream request level
//     aclken            AXI clock enable, qualifies beats
//     vtd_vblank        vertical blank from the bridge (aclk domain)
//     wr_error          bridge FIFO overflow flag (aclk domain)
//     axis              monitored AXI4-Stream video bus (monitor modport)
//     axis_enable       enable to the bridge
//     bridge_rst        active-high reset to the bridge
//     state             FSM encoding: IDLE=0 WAIT_VB=1 ARMED=2 STREAM=3 RECOVER=4
//     frame_count       start-of-frame beats accepted while streaming (wraps)
//     err_count         wr_error and timeout events (saturates)
//     timeout_flag      sticky timeout indication, cleared by run=0
//     meas_width        beats in the last complete line
//     meas_height       lines in the last complete frame
//     size_err          sticky line-width mismatch within a frame
//
//   Build option:
//     VID_IN_CTRL_MEASURE_EN  when defined, builds the line/frame size
//     measurement; otherwise meas_width, meas_height and size_err are 0.
// ---------------------------------------------------------------------------
module vid_in_stream_ctrl #(
  parameter int CNT_WIDTH      = 16,
  parameter int ERR_WIDTH      = 8,
  parameter int RST_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      aclken,
  input  logic                      vtd_vblank,
  input  logic                      wr_error,
  vid_in_stream_ctrl_if.monitor     axis,
  output logic                      axis_enable,
  output logic                      bridge_rst,
  output logic [2:0]                state,
  output logic [CNT_WIDTH-1:0]      frame_count,
  output logic [ERR_WIDTH-1:0]      err_count,
  output logic                      timeout_flag,
  output logic [CNT_WIDTH-1:0]      meas_width,
  output logic [CNT_WIDTH-1:0]      meas_height,
  output logic                      size_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    ARMED   = 3'd2,
    STREAM  = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  state_t          cur_st;
  state_t          nxt_st;
  logic            vb_q;
  logic            vb_rise;
  logic            beat;
  logic            sof;
  logic            stop_pend;
  logic [TO_W-1:0] to_cnt;
  logic [RC_W-1:0] rc_cnt;
  logic            frame_inc;
  logic            err_evt;
  logic            timeout_hit;

  assign beat    = axis.m_axis_video_tvalid & axis.m_axis_video_tready & aclken;
  assign sof     = beat & axis.m_axis_video_tuser;
  assign vb_rise = vtd_vblank & ~vb_q;
  assign state   = cur_st;

  // Next-state and event decode. In ARMED/STREAM a write error outranks
  // everything else; in ARMED a stop request outranks sof, and sof outranks
  // the timeout.
  always_comb begin
    nxt_st      = cur_st;
    frame_inc   = 1'b0;
    err_evt     = 1'b0;
    timeout_hit = 1'b0;
    case (cur_st)
      IDLE: begin
        if (run) nxt_st = WAIT_VB;
      end
      WAIT_VB: begin
        if (!run)        nxt_st = IDLE;
        else if (vb_rise) nxt_st = ARMED;
      end
      ARMED: begin
        if (wr_error) begin
          nxt_st  = RECOVER;
          err_evt = 1'b1;
        end else if (!run) begin
          nxt_st = IDLE;
        end else if (sof) begin
          nxt_st    = STREAM;
          frame_inc = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          nxt_st      = RECOVER;
          err_evt     = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      STREAM: begin
        if (wr_error) begin
          nxt_st  = RECOVER;
          err_evt = 1'b1;
        end else begin
          frame_inc = sof;
          // Only stop on the blanking edge so the bridge never sees a
          // partial frame.
          if (vb_rise && stop_pend) nxt_st = IDLE;
        end
      end
      RECOVER: begin
        if (rc_cnt == RC_LAST) nxt_st = WAIT_VB;
      end
      default: nxt_st = IDLE;
    endcase
  end

  // Control registers; outputs follow the next state so they change in
  // the same cycle as the state encoding.
  always_ff @(posedge aclk) begin
    if (rst) begin
      cur_st       <= IDLE;
      vb_q         <= 1'b1;
      axis_enable  <= 1'b0;
      bridge_rst   <= 1'b0;
      stop_pend    <= 1'b0;
      to_cnt       <= '0;
      rc_cnt       <= '0;
      frame_count  <= '0;
      err_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      vb_q        <= vtd_vblank;
      axis_enable <= (nxt_st == ARMED) || (nxt_st == STREAM);
      bridge_rst  <= (nxt_st == RECOVER);
      stop_pend   <= (cur_st == STREAM) && (nxt_st == STREAM) && !run;
      to_cnt      <= (cur_st == ARMED) ? to_cnt + TO_W'(1) : '0;
      rc_cnt      <= (cur_st == RECOVER) ? rc_cnt + RC_W'(1) : '0;
      frame_count <= frame_count + {{(CNT_WIDTH-1){1'b0}}, frame_inc};
      if (err_evt) err_count <= sat_inc(err_count);
      if (!run)             timeout_flag <= 1'b0;
      else if (timeout_hit) timeout_flag <= 1'b1;
    end
  end

`ifdef VID_IN_CTRL_MEASURE_EN
  logic                 eol;
  logic                 meas_act;
  logic                 size_mis;
  logic [CNT_WIDTH-1:0] pix_cnt;
  logic [CNT_WIDTH-1:0] line_cnt;
  logic [CNT_WIDTH-1:0] line_w;
  logic [CNT_WIDTH-1:0] first_w;
  logic                 first_vld;
  logic                 have_frame;

  assign eol = beat & axis.m_axis_video_tlast;
  // The sof that moves ARMED to STREAM is the first beat of the first
  // frame, so it is measured too.
  assign meas_act = beat && ((cur_st == STREAM) || ((cur_st == ARMED) && frame_inc));
  // A sof restarts the line, so that beat counts as beat 1.
  assign line_w   = (sof ? '0 : pix_cnt) + CNT_WIDTH'(1);
  assign size_mis = meas_act && eol && !sof && first_vld && (line_w != first_w);

  always_ff @(posedge aclk) begin
    if (rst) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      first_w     <= '0;
      first_vld   <= 1'b0;
      have_frame  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      size_err    <= 1'b0;
    end else begin
      if (meas_act) begin
        pix_cnt <= eol ? '0 : line_w;
        if (eol) meas_width <= line_w;
        if (sof) begin
          line_cnt   <= eol ? CNT_WIDTH'(1) : '0;
          have_frame <= 1'b1;
          // The first frame after (re)start may be partial; skip it.
          if (have_frame) meas_height <= line_cnt;
        end else if (eol) begin
          line_cnt <= line_cnt + CNT_WIDTH'(1);
        end
        if (eol && (sof || !first_vld)) begin
          first_w   <= line_w;
          first_vld <= 1'b1;
        end else if (sof) begin
          first_vld <= 1'b0;
        end
      end else if (cur_st != STREAM) begin
        pix_cnt    <= '0;
        line_cnt   <= '0;
        first_vld  <= 1'b0;
        have_frame <= 1'b0;
      end
      if (!run)          size_err <= 1'b0;
      else if (size_mis) size_err <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = axis.m_axis_video_tlast;
  assign meas_width   = '0;
  assign meas_height  = '0;
  assign size_err     = 1'b0;
`endif

endmodule
